// File: rtl/rs_alloc_issue_ctrl_if.sv
// rs_alloc_issue_ctrl_if: dispatch, entry-status and issue signals between the RS array and its controller.
interface rs_alloc_issue_ctrl_if #(
    parameter int RS_DEPTH   = 16,
    parameter int DISP_WIDTH = 2,
    parameter int FU_NUM     = 8
);
    localparam int IW = $clog2(RS_DEPTH);
    localparam int TW = $clog2(FU_NUM);
    logic [DISP_WIDTH-1:0]          disp_valid_i;
    logic [DISP_WIDTH-1:0]          disp_grant_o;
    logic [DISP_WIDTH-1:0][IW-1:0]  disp_idx_o;
    logic [RS_DEPTH-1:0]            disp_enable_o;
    logic                           disp_stall_o;
    logic [RS_DEPTH-1:0]            entry_empty_i;
    logic [RS_DEPTH-1:0]            entry_ready_i;
    logic [RS_DEPTH-1:0][TW-1:0]    entry_fu_type_i;
    logic [FU_NUM-1:0]              fu_avail_i;
    logic [RS_DEPTH-1:0]            issue_o;
    logic [FU_NUM-1:0]              issue_valid_o;
    logic [FU_NUM-1:0][IW-1:0]      issue_idx_o;
    logic [IW:0]                    free_cnt_o;
    modport master (
        output disp_valid_i, entry_empty_i, entry_ready_i, entry_fu_type_i, fu_avail_i,
        input  disp_grant_o, disp_idx_o, disp_enable_o, disp_stall_o,
        input  issue_o, issue_valid_o, issue_idx_o, free_cnt_o
    );
    modport slave (
        input  disp_valid_i, entry_empty_i, entry_ready_i, entry_fu_type_i, fu_avail_i,
        output disp_grant_o, disp_idx_o, disp_enable_o, disp_stall_o,
        output issue_o, issue_valid_o, issue_idx_o, free_cnt_o
    );
endinterface

// File: rtl/rs_alloc_issue_ctrl.sv
// rs_alloc_issue_ctrl: RS entry allocation, per-FU round-robin issue select and free-entry count.
// Optional RS_CTRL_PERF_EN adds saturating stall/issue counters and a free-count consistency check.
module rs_alloc_issue_ctrl #(
    parameter int RS_DEPTH   = 16,
    parameter int DISP_WIDTH = 2,
    parameter int FU_NUM     = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic flush,
    rs_alloc_issue_ctrl_if.slave bus
`ifdef RS_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles_o,
    output logic [31:0] perf_issue_cnt_o
`endif
);
    localparam int IW = $clog2(RS_DEPTH);
    localparam int TW = $clog2(FU_NUM);
    localparam int CW = IW + 1;

    logic                          kill;
    logic [CW-1:0]                 free_q;
    logic [FU_NUM-1:0][IW-1:0]     rr_q;
    logic [DISP_WIDTH-1:0]         lane_has;
    logic [DISP_WIDTH-1:0][IW-1:0] lane_idx;
    logic [DISP_WIDTH-1:0]         grant;
    logic [FU_NUM-1:0]             iv;
    logic [FU_NUM-1:0][IW-1:0]     ii;

    assign kill = reset | flush;

    // Lane k is offered the k-th lowest empty entry.
    always_comb begin : find_empty
        int n;
        n = 0;
        lane_has = '0;
        lane_idx = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (bus.entry_empty_i[i]) begin
                for (int k = 0; k < DISP_WIDTH; k++) begin
                    if (n == k) begin
                        lane_has[k] = 1'b1;
                        lane_idx[k] = IW'(i);
                    end
                end
                n = n + 1;
            end
        end
    end

    always_comb begin : alloc
        logic ok;
        ok = ~kill;
        grant = '0;
        bus.disp_idx_o = '0;
        bus.disp_enable_o = '0;
        for (int k = 0; k < DISP_WIDTH; k++) begin
            ok = ok & bus.disp_valid_i[k] & lane_has[k];
            grant[k] = ok;
            if (ok) begin
                bus.disp_idx_o[k] = lane_idx[k];
                bus.disp_enable_o[lane_idx[k]] = 1'b1;
            end
        end
    end

    assign bus.disp_grant_o = grant;
    assign bus.disp_stall_o = ~kill & |(bus.disp_valid_i & ~grant);

    always_comb begin : select
        logic [IW-1:0] e;
        e = '0;
        iv = '0;
        ii = '0;
        bus.issue_o = '0;
        for (int f = 0; f < FU_NUM; f++) begin
            for (int j = 0; j < RS_DEPTH; j++) begin
                e = rr_q[f] + IW'(j);
                if (!kill && !iv[f] && bus.fu_avail_i[f] && bus.entry_ready_i[e] &&
                    !bus.entry_empty_i[e] && bus.entry_fu_type_i[e] == TW'(f)) begin
                    iv[f] = 1'b1;
                    ii[f] = e;
                end
            end
        end
        for (int f = 0; f < FU_NUM; f++)
            if (iv[f]) bus.issue_o[ii[f]] = 1'b1;
    end

    assign bus.issue_valid_o = iv;
    assign bus.issue_idx_o   = ii;
    assign bus.free_cnt_o    = free_q;

    always_ff @(posedge clock) begin
        if (kill) begin
            free_q <= CW'(RS_DEPTH);
            rr_q   <= '0;
        end else begin
            free_q <= free_q - CW'($countones(grant)) + CW'($countones(bus.issue_o));
            for (int f = 0; f < FU_NUM; f++)
                if (iv[f]) rr_q[f] <= ii[f] + IW'(1);
        end
    end

`ifdef RS_CTRL_PERF_EN
    logic [32:0] issue_sum;
    assign issue_sum = {1'b0, perf_issue_cnt_o} + 33'($countones(bus.issue_o));

    // Flush does not clear the counters; both saturate at all-ones.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_stall_cycles_o <= '0;
            perf_issue_cnt_o    <= '0;
        end else begin
            if (bus.disp_stall_o && !(&perf_stall_cycles_o))
                perf_stall_cycles_o <= perf_stall_cycles_o + 32'd1;
            perf_issue_cnt_o <= issue_sum[32] ? '1 : issue_sum[31:0];
        end
    end

`ifndef SYNTHESIS
    logic seen_reset_q;
    always_ff @(posedge clock) begin
        if (reset) seen_reset_q <= 1'b1;
        else if (seen_reset_q) assert (free_q == CW'($countones(bus.entry_empty_i)));
    end
`endif
`endif
endmodule

// File: tb/tb_rs_alloc_issue_ctrl.sv
// tb_rs_alloc_issue_ctrl: directed scenarios plus a randomized run against a queue/array reference model.
module tb_rs_alloc_issue_ctrl;
    localparam int RS = 16;
    localparam int DW = 2;
    localparam int FU = 8;
    localparam int IW = 4;
    localparam int TW = 3;

    logic clock = 1'b0;
    logic reset;
    logic flush;
    int compared = 0;
    int mismatched = 0;
    int exp_free = RS;

    always #5 clock = ~clock;

    rs_alloc_issue_ctrl_if #(.RS_DEPTH(RS), .DISP_WIDTH(DW), .FU_NUM(FU)) bus();
`ifdef RS_CTRL_PERF_EN
    logic [31:0] perf_stall, perf_issue;
`endif

    rs_alloc_issue_ctrl #(.RS_DEPTH(RS), .DISP_WIDTH(DW), .FU_NUM(FU)) dut (
        .clock(clock),
        .reset(reset),
        .flush(flush),
        .bus(bus)
`ifdef RS_CTRL_PERF_EN
        ,
        .perf_stall_cycles_o(perf_stall),
        .perf_issue_cnt_o(perf_issue)
`endif
    );

    task automatic clear_inputs();
        flush = 1'b0;
        bus.disp_valid_i = '0;
        bus.entry_empty_i = '1;
        bus.entry_ready_i = '0;
        bus.entry_fu_type_i = '0;
        bus.fu_avail_i = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        bus.disp_valid_i = 2'b11;
        bus.entry_empty_i = 16'hfffe;
        bus.entry_ready_i = 16'h0001;
        bus.fu_avail_i = '1;
        @(negedge clock);
        @(negedge clock);
        #1;
        compared++; if (bus.disp_grant_o !== 2'b00) begin mismatched++; $display("FAIL reset_grant: got %b want 00", bus.disp_grant_o); end
        compared++; if (bus.disp_enable_o !== 16'h0) begin mismatched++; $display("FAIL reset_enable: got %h want 0", bus.disp_enable_o); end
        compared++; if (bus.disp_stall_o !== 1'b0) begin mismatched++; $display("FAIL reset_stall: got %b want 0", bus.disp_stall_o); end
        compared++; if (bus.disp_idx_o !== 8'h0) begin mismatched++; $display("FAIL reset_idx: got %h want 0", bus.disp_idx_o); end
        compared++; if (bus.issue_valid_o !== 8'h0 || bus.issue_o !== 16'h0) begin mismatched++; $display("FAIL reset_issue: got %h/%h want 0/0", bus.issue_valid_o, bus.issue_o); end
        reset = 1'b0;
        clear_inputs();
        @(negedge clock);
        exp_free = RS;
        compared++; if (bus.free_cnt_o !== 5'(exp_free)) begin mismatched++; $display("FAIL reset_free: got %0d want %0d", bus.free_cnt_o, exp_free); end
    endtask

    task automatic test_alloc_basic();
        bus.entry_empty_i = '1;
        bus.disp_valid_i = 2'b11;
        #1;
        compared++; if (bus.disp_grant_o !== 2'b11) begin mismatched++; $display("FAIL alloc_grant: got %b want 11", bus.disp_grant_o); end
        compared++; if (bus.disp_idx_o[0] !== 4'd0 || bus.disp_idx_o[1] !== 4'd1) begin mismatched++; $display("FAIL alloc_idx: got %0d,%0d want 0,1", bus.disp_idx_o[0], bus.disp_idx_o[1]); end
        compared++; if (bus.disp_enable_o !== 16'h0003) begin mismatched++; $display("FAIL alloc_enable: got %h want 0003", bus.disp_enable_o); end
        compared++; if (bus.disp_stall_o !== 1'b0) begin mismatched++; $display("FAIL alloc_stall: got %b want 0", bus.disp_stall_o); end
        @(negedge clock);
        bus.disp_valid_i = '0;
        exp_free -= 2;
        compared++; if (bus.free_cnt_o !== 5'(exp_free)) begin mismatched++; $display("FAIL alloc_free: got %0d want %0d", bus.free_cnt_o, exp_free); end
        for (int c = 0; c < 6; c++) begin
            bus.disp_valid_i = 2'b11;
            @(negedge clock);
        end
        bus.disp_valid_i = 2'b01;
        @(negedge clock);
        bus.disp_valid_i = '0;
        exp_free -= 13;
        compared++; if (bus.free_cnt_o !== 5'(exp_free)) begin mismatched++; $display("FAIL fill_free: got %0d want %0d", bus.free_cnt_o, exp_free); end
    endtask

    task automatic test_alloc_last();
        bus.entry_empty_i = 16'h8000;
        bus.disp_valid_i = 2'b11;
        #1;
        compared++; if (bus.disp_grant_o !== 2'b01) begin mismatched++; $display("FAIL last_grant: got %b want 01", bus.disp_grant_o); end
        compared++; if (bus.disp_idx_o[0] !== 4'd15) begin mismatched++; $display("FAIL last_idx: got %0d want 15", bus.disp_idx_o[0]); end
        compared++; if (bus.disp_enable_o !== 16'h8000) begin mismatched++; $display("FAIL last_enable: got %h want 8000", bus.disp_enable_o); end
        compared++; if (bus.disp_stall_o !== 1'b1) begin mismatched++; $display("FAIL last_stall: got %b want 1", bus.disp_stall_o); end
        @(negedge clock);
        exp_free -= 1;
        compared++; if (bus.free_cnt_o !== 5'(exp_free)) begin mismatched++; $display("FAIL last_free: got %0d want %0d", bus.free_cnt_o, exp_free); end
        bus.entry_empty_i = '0;
        bus.entry_ready_i = 16'h0008;
        bus.entry_fu_type_i[3] = 3'd5;
        bus.fu_avail_i = 8'h20;
        #1;
        compared++; if (bus.disp_grant_o !== 2'b00 || bus.disp_stall_o !== 1'b1) begin mismatched++; $display("FAIL full_grant: got %b stall %b want 00 stall 1", bus.disp_grant_o, bus.disp_stall_o); end
        compared++; if (bus.issue_o !== 16'h0008) begin mismatched++; $display("FAIL full_issue: got %h want 0008", bus.issue_o); end
        @(negedge clock);
        exp_free += 1;
        clear_inputs();
        bus.entry_empty_i = '0;
        #1;
        compared++; if (bus.disp_stall_o !== 1'b0) begin mismatched++; $display("FAIL idle_stall: got %b want 0", bus.disp_stall_o); end
        compared++; if (bus.free_cnt_o !== 5'(exp_free)) begin mismatched++; $display("FAIL full_free: got %0d want %0d", bus.free_cnt_o, exp_free); end
        @(negedge clock);
    endtask

    task automatic test_rr_issue();
        int seq[3] = '{2, 5, 9};
        clear_inputs();
        bus.entry_empty_i = '0;
        for (int s = 0; s < 3; s++) begin
            bus.entry_ready_i[seq[s]] = 1'b1;
            bus.entry_fu_type_i[seq[s]] = 3'd3;
        end
        bus.fu_avail_i = 8'h08;
        for (int s = 0; s < 3; s++) begin
            #1;
            compared++; if (bus.issue_valid_o !== 8'h08 || bus.issue_idx_o[3] !== 4'(seq[s])) begin mismatched++; $display("FAIL rr_idx: got %h/%0d want 08/%0d", bus.issue_valid_o, bus.issue_idx_o[3], seq[s]); end
            compared++; if (bus.issue_o !== (16'h1 << seq[s])) begin mismatched++; $display("FAIL rr_strobe: got %h want %h", bus.issue_o, 16'h1 << seq[s]); end
            @(negedge clock);
            exp_free += 1;
            compared++; if (bus.free_cnt_o !== 5'(exp_free)) begin mismatched++; $display("FAIL rr_free: got %0d want %0d", bus.free_cnt_o, exp_free); end
            bus.entry_ready_i[seq[s]] = 1'b0;
            bus.entry_empty_i[seq[s]] = 1'b1;
        end
        bus.entry_empty_i[2] = 1'b0;
        bus.entry_ready_i[2] = 1'b1;
        bus.entry_ready_i[11] = 1'b1;
        bus.entry_fu_type_i[11] = 3'd3;
        #1;
        compared++; if (bus.issue_idx_o[3] !== 4'd11) begin mismatched++; $display("FAIL rr_after9: got %0d want 11", bus.issue_idx_o[3]); end
        @(negedge clock);
        exp_free += 1;
        bus.entry_ready_i[11] = 1'b0;
        bus.entry_empty_i[11] = 1'b1;
        #1;
        compared++; if (bus.issue_idx_o[3] !== 4'd2 || bus.issue_valid_o !== 8'h08) begin mismatched++; $display("FAIL rr_wrap: got %0d/%h want 2/08", bus.issue_idx_o[3], bus.issue_valid_o); end
        @(negedge clock);
        exp_free += 1;
        clear_inputs();
        compared++; if (bus.free_cnt_o !== 5'(exp_free)) begin mismatched++; $display("FAIL rr_end_free: got %0d want %0d", bus.free_cnt_o, exp_free); end
    endtask

    task automatic test_dual_issue();
        clear_inputs();
        bus.entry_empty_i = '0;
        bus.entry_ready_i = 16'h00c0;
        bus.entry_fu_type_i[7] = 3'd1;
        bus.fu_avail_i = 8'h03;
        #1;
        compared++; if (bus.issue_valid_o !== 8'h03) begin mismatched++; $display("FAIL dual_valid: got %h want 03", bus.issue_valid_o); end
        compared++; if (bus.issue_o !== 16'h00c0) begin mismatched++; $display("FAIL dual_strobe: got %h want 00c0", bus.issue_o); end
        compared++; if (bus.issue_idx_o[0] !== 4'd6 || bus.issue_idx_o[1] !== 4'd7) begin mismatched++; $display("FAIL dual_idx: got %0d,%0d want 6,7", bus.issue_idx_o[0], bus.issue_idx_o[1]); end
        @(negedge clock);
        exp_free += 2;
        clear_inputs();
        compared++; if (bus.free_cnt_o !== 5'(exp_free)) begin mismatched++; $display("FAIL dual_free: got %0d want %0d", bus.free_cnt_o, exp_free); end
    endtask

    task automatic test_fu_unavail();
        clear_inputs();
        bus.entry_empty_i = '0;
        bus.entry_ready_i = 16'h0210;
        bus.entry_fu_type_i[4] = 3'd2;
        bus.entry_fu_type_i[9] = 3'd2;
        bus.fu_avail_i = 8'hfb;
        #1;
        compared++; if (bus.issue_valid_o !== 8'h00 || bus.issue_o !== 16'h0) begin mismatched++; $display("FAIL unavail_issue: got %h/%h want 00/0000", bus.issue_valid_o, bus.issue_o); end
        @(negedge clock);
        compared++; if (bus.free_cnt_o !== 5'(exp_free)) begin mismatched++; $display("FAIL unavail_free: got %0d want %0d", bus.free_cnt_o, exp_free); end
        bus.fu_avail_i = 8'hff;
        #1;
        compared++; if (bus.issue_valid_o !== 8'h04 || bus.issue_idx_o[2] !== 4'd4) begin mismatched++; $display("FAIL unavail_resume: got %h/%0d want 04/4", bus.issue_valid_o, bus.issue_idx_o[2]); end
        @(negedge clock);
        exp_free += 1;
        clear_inputs();
        compared++; if (bus.free_cnt_o !== 5'(exp_free)) begin mismatched++; $display("FAIL resume_free: got %0d want %0d", bus.free_cnt_o, exp_free); end
    endtask

    task automatic test_flush();
        clear_inputs();
        while (exp_free > 6) begin
            bus.disp_valid_i = (exp_free - 6 >= 2) ? 2'b11 : 2'b01;
            @(negedge clock);
            exp_free -= (exp_free - 6 >= 2) ? 2 : 1;
        end
        bus.disp_valid_i = '0;
        #1;
        compared++; if (bus.free_cnt_o !== 5'd6) begin mismatched++; $display("FAIL preflush_free: got %0d want 6", bus.free_cnt_o); end
        flush = 1'b1;
        bus.disp_valid_i = 2'b11;
        bus.entry_empty_i = 16'hffdf;
        bus.entry_ready_i = 16'h0020;
        bus.entry_fu_type_i[5] = 3'd3;
        bus.fu_avail_i = '1;
        #1;
        compared++; if (bus.disp_grant_o !== 2'b00 || bus.disp_enable_o !== 16'h0 || bus.disp_idx_o !== 8'h0) begin mismatched++; $display("FAIL flush_disp: got %b/%h/%h want 00/0/0", bus.disp_grant_o, bus.disp_enable_o, bus.disp_idx_o); end
        compared++; if (bus.disp_stall_o !== 1'b0) begin mismatched++; $display("FAIL flush_stall: got %b want 0", bus.disp_stall_o); end
        compared++; if (bus.issue_valid_o !== 8'h0 || bus.issue_o !== 16'h0 || bus.issue_idx_o !== 32'h0) begin mismatched++; $display("FAIL flush_issue: got %h/%h/%h want 0/0/0", bus.issue_valid_o, bus.issue_o, bus.issue_idx_o); end
        @(negedge clock);
        clear_inputs();
        exp_free = RS;
        compared++; if (bus.free_cnt_o !== 5'(exp_free)) begin mismatched++; $display("FAIL flush_free: got %0d want %0d", bus.free_cnt_o, exp_free); end
        bus.entry_empty_i = '0;
        bus.entry_ready_i = 16'h0066;
        bus.entry_fu_type_i[1] = 3'd3;
        bus.entry_fu_type_i[5] = 3'd3;
        bus.entry_fu_type_i[2] = 3'd5;
        bus.entry_fu_type_i[6] = 3'd5;
        bus.fu_avail_i = 8'h28;
        #1;
        compared++; if (bus.issue_idx_o[3] !== 4'd1 || bus.issue_idx_o[5] !== 4'd2) begin mismatched++; $display("FAIL flush_ptr: got %0d,%0d want 1,2", bus.issue_idx_o[3], bus.issue_idx_o[5]); end
        clear_inputs();
        @(negedge clock);
    endtask

    task automatic test_random();
        logic [RS-1:0] env_empty, env_ready;
        logic [TW-1:0] env_type [RS];
        int rr [FU];
        int q[$];
        logic fl, ok;
        logic [DW-1:0] valid, eg;
        logic [DW-1:0][IW-1:0] eidx;
        logic [RS-1:0] een, eiss;
        logic [FU-1:0] avail, eiv;
        logic [FU-1:0][IW-1:0] eii;
        logic est;
        int e;
        clear_inputs();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        env_empty = '1;
        env_ready = '0;
        for (int i = 0; i < RS; i++) env_type[i] = '0;
        for (int f = 0; f < FU; f++) rr[f] = 0;
        exp_free = RS;
        for (int c = 0; c < 600; c++) begin
            compared++; if (bus.free_cnt_o !== 5'(exp_free)) begin mismatched++; $display("FAIL rnd_free c%0d: got %0d want %0d", c, bus.free_cnt_o, exp_free); end
            fl = ($urandom_range(0, 31) == 0);
            for (int i = 0; i < RS; i++)
                if (!env_empty[i] && !env_ready[i] && $urandom_range(0, 2) == 0) env_ready[i] = 1'b1;
            valid = DW'((1 << $urandom_range(0, DW)) - 1);
            avail = FU'($urandom);
            flush = fl;
            bus.disp_valid_i = valid;
            bus.entry_empty_i = env_empty;
            bus.entry_ready_i = env_ready;
            for (int i = 0; i < RS; i++) bus.entry_fu_type_i[i] = env_type[i];
            bus.fu_avail_i = avail;
            q = {};
            for (int i = 0; i < RS; i++) if (env_empty[i]) q.push_back(i);
            eg = '0; eidx = '0; een = '0; ok = !fl;
            for (int k = 0; k < DW; k++) begin
                ok = ok && valid[k] && (k < q.size());
                if (ok) begin eg[k] = 1'b1; eidx[k] = IW'(q[k]); een[q[k]] = 1'b1; end
            end
            est = !fl && (|(valid & ~eg));
            eiv = '0; eii = '0; eiss = '0;
            for (int f = 0; f < FU; f++) begin
                for (int j = 0; j < RS; j++) begin
                    e = (rr[f] + j) % RS;
                    if (!fl && avail[f] && !eiv[f] && env_ready[e] && !env_empty[e] && env_type[e] == TW'(f)) begin
                        eiv[f] = 1'b1; eii[f] = IW'(e); eiss[e] = 1'b1;
                    end
                end
            end
            #1;
            compared++; if (bus.disp_grant_o !== eg || bus.disp_idx_o !== eidx) begin mismatched++; $display("FAIL rnd_grant c%0d: got %b/%h want %b/%h", c, bus.disp_grant_o, bus.disp_idx_o, eg, eidx); end
            compared++; if (bus.disp_enable_o !== een || bus.disp_stall_o !== est) begin mismatched++; $display("FAIL rnd_enable c%0d: got %h/%b want %h/%b", c, bus.disp_enable_o, bus.disp_stall_o, een, est); end
            compared++; if (bus.issue_valid_o !== eiv || bus.issue_idx_o !== eii) begin mismatched++; $display("FAIL rnd_issue c%0d: got %h/%h want %h/%h", c, bus.issue_valid_o, bus.issue_idx_o, eiv, eii); end
            compared++; if (bus.issue_o !== eiss) begin mismatched++; $display("FAIL rnd_strobe c%0d: got %h want %h", c, bus.issue_o, eiss); end
            if (fl) begin
                env_empty = '1;
                env_ready = '0;
                for (int f = 0; f < FU; f++) rr[f] = 0;
                exp_free = RS;
            end else begin
                for (int k = 0; k < DW; k++) if (eg[k]) begin
                    env_empty[q[k]] = 1'b0;
                    env_ready[q[k]] = 1'($urandom_range(0, 1));
                    env_type[q[k]] = TW'($urandom_range(0, FU - 1));
                end
                for (int f = 0; f < FU; f++) if (eiv[f]) begin
                    env_empty[eii[f]] = 1'b1;
                    env_ready[eii[f]] = 1'b0;
                    rr[f] = (int'(eii[f]) + 1) % RS;
                end
                exp_free = exp_free - $countones(eg) + $countones(eiss);
            end
            @(negedge clock);
        end
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_alloc_basic();
        test_alloc_last();
        test_rr_issue();
        test_dual_issue();
        test_fu_unavail();
        test_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/rs_alloc_issue_ctrl.md
Name: rs_alloc_issue_ctrl

Overview:
- Reservation-station control block. Sits between dispatch/rename and an array of RS_DEPTH single RS entries, and feeds the FU issue stage.
- Allocates empty entries to in-order dispatch lanes.
- Each cycle, selects at most one ready entry per FU type using a per-FU round-robin pointer.
- Tracks the registered free-entry count used for dispatch back-pressure.

Parameters:
- RS_DEPTH, 16, number of RS entries (power of two, >= 4).
- DISP_WIDTH, 2, dispatch lanes per cycle (1..4).
- FU_NUM, 8, number of FU types; fu_type width is $clog2(FU_NUM).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  mispredict flush; squashes all entries.
- disp_valid_i  in  DISP_WIDTH  lane k has an instruction; lanes are contiguous from lane 0.
- disp_grant_o  out  DISP_WIDTH  lane k accepted this cycle.
- disp_idx_o  out  DISP_WIDTH x $clog2(RS_DEPTH)  entry index assigned to lane k; valid only when granted.
- disp_enable_o  out  RS_DEPTH  one-hot-per-lane write enables to the entries.
- disp_stall_o  out  1  some valid lane was not granted.
- entry_empty_i  in  RS_DEPTH  empty flags from the entries.
- entry_ready_i  in  RS_DEPTH  operands-ready flags from the entries.
- entry_fu_type_i  in  RS_DEPTH x $clog2(FU_NUM)  FU type of each entry.
- fu_avail_i  in  FU_NUM  FU type f can accept an issue this cycle.
- issue_o  out  RS_DEPTH  issue strobe to each entry.
- issue_valid_o  out  FU_NUM  FU f gets an instruction this cycle.
- issue_idx_o  out  FU_NUM x $clog2(RS_DEPTH)  selected entry index for FU f.
- free_cnt_o  out  $clog2(RS_DEPTH)+1  registered count of free entries.

Behaviour:
- Reset values:
  - free_cnt_o = RS_DEPTH.
  - All round-robin pointers = 0.
  - While reset or flush is high, all combinational outputs are forced to 0: disp_grant_o, disp_enable_o, issue_o, issue_valid_o, disp_stall_o, disp_idx_o, issue_idx_o.
- Allocation (combinational, same cycle):
  - Lane 0 takes the lowest-index empty entry, lane 1 the next-lowest, and so on.
  - Lane k is granted only if disp_valid_i[k], lanes 0..k-1 are granted, and an empty entry remains. Lanes are never granted out of order.
  - disp_enable_o is the OR of the one-hot decodes of the granted lanes.
  - disp_stall_o = |(disp_valid_i & ~disp_grant_o).
- Issue candidate for FU f: entry_ready_i[i] & ~entry_empty_i[i] & (entry_fu_type_i[i]==f) & fu_avail_i[f].
- Issue select (combinational, same cycle):
  - For each FU f, pick the first candidate at or after rr_ptr[f], wrapping modulo RS_DEPTH.
  - At most one grant per FU. Each entry belongs to exactly one FU type, so issue_o is conflict-free.
- Pointer update (registered):
  - When issue_valid_o[f] is high, rr_ptr[f] <= issue_idx_o[f]+1, wrapping from RS_DEPTH-1 to 0.
  - Otherwise rr_ptr[f] holds.
- Free count:
  - free_cnt_q <= free_cnt_q - popcount(disp_grant_o) + popcount(issue_o).
  - Dispatch into an entry and issue from the same entry cannot occur in one cycle, because only empty entries are allocated.
- Flush: next cycle free_cnt_q = RS_DEPTH and all rr_ptr = 0. Entries clear themselves via their own flush input.
- Boundaries:
  - Full array (no empty entries): all grants 0; disp_stall_o = |disp_valid_i.
  - Simultaneous issue and dispatch when full: the freed entry is not reusable until the next cycle, because empty is registered in the entry.
  - A candidate whose fu_avail_i is 0 is skipped without moving the pointer.
- Latency: allocation and select are 0-cycle; bookkeeping registers update at the next posedge.

Optional Feature:
- Macro RS_CTRL_PERF_EN.
- When defined, adds:
  - 32-bit output perf_stall_cycles_o, counting cycles with disp_stall_o = 1.
  - 32-bit output perf_issue_cnt_o, accumulating popcount(issue_o).
  - Both counters reset to 0 on reset, are not cleared by flush, and saturate at 2^32-1.
  - A simulation-only check that free_cnt_q == popcount(entry_empty_i) every cycle after reset.
- When undefined: these ports and the check do not exist; all other behaviour is identical.

Test Plan:
1. Reset, then disp_valid_i=2'b11 with all 16 entries empty -> disp_idx_o = {1,0}, grants 2'b11, next-cycle free_cnt_o=14.
2. Only entry 15 empty, disp_valid_i=2'b11 -> lane0 granted idx 15, lane1 not granted, disp_stall_o=1; next cycle free_cnt_o=0.
3. Entries 2, 5, 9 ready with FU type 3, fu_avail_i[3]=1 for three cycles -> issue_idx_o[3] = 2, then 5, then 9; rr_ptr[3]=10 afterwards.
4. Two ready entries of types 0 and 1 in the same cycle, both FUs available -> both issue_valid_o bits high and issue_o has two bits set; free_cnt_o rises by 2.
5. Entry 4 ready with type 2 and fu_avail_i[2]=0 -> no issue and rr_ptr[2] unchanged; when fu_avail_i[2]=1 the next cycle, entry 4 issues.
6. flush asserted with free_cnt_o=6 and a valid dispatch -> no grants that cycle; free_cnt_o=16 and pointers 0 the next cycle.
